// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg: shared widths, opcodes and default ALU latency for the FP ALU dispatcher
package fp_alu_pkg;
  localparam int   FP_W            = 32;
  localparam logic OP_ADD          = 1'b0;
  localparam logic OP_MUL          = 1'b1;
  localparam int   ALU_LATENCY_DEF = 2;
endpackage

// File: rtl/fp_sync_fifo.sv
// fp_sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/din_i write; pop_i read;
//        dout_o head entry (valid while !empty_o); full_o/empty_o occupancy flags.
// The caller never pushes when full nor pops when empty.
module fp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/fp_alu_dispatcher.sv
// fp_alu_dispatcher: credit-based issue stage feeding a fixed-latency FP ALU and returning tagged results
// Ports: req_* tagged operand requests (valid/ready); alu_x/alu_y/alu_op registered ALU operands,
//        alu_op one cycle behind x/y; alu_result/alu_overflow ALU outputs; rsp_* tagged responses
//        (valid/ready, zero when empty); cnt_clr/ovf_count saturating overflow counter; busy activity flag.
module fp_alu_dispatcher import fp_alu_pkg::*; #(
  parameter int DEPTH       = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int TAG_W       = 4,
  parameter int ALU_LATENCY = ALU_LATENCY_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [FP_W-1:0]  req_x_i,
  input  logic [FP_W-1:0]  req_y_i,
  input  logic             req_op_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [FP_W-1:0]  alu_x_o,
  output logic [FP_W-1:0]  alu_y_o,
  output logic             alu_op_o,
  input  logic [FP_W-1:0]  alu_result_i,
  input  logic             alu_overflow_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [FP_W-1:0]  rsp_result_o,
  output logic             rsp_overflow_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  input  logic             cnt_clr_i,
  output logic [15:0]      ovf_count_o,
  output logic             busy_o
);
  localparam int RW = 2*FP_W + 1 + TAG_W;
  localparam int SW = FP_W + 1 + TAG_W;
  localparam int PS = ALU_LATENCY + 2;
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  logic                      req_full, req_empty, rsp_full, rsp_empty;
  logic [RW-1:0]             req_head;
  logic [SW-1:0]             rsp_head;
  logic [FP_W-1:0]           hx, hy;
  logic                      hop;
  logic [TAG_W-1:0]          htag;
  logic                      issue, rsp_pop, cap, ovf_cap;
  logic [FP_W-1:0]           alu_x_q, alu_y_q;
  logic                      op_q, alu_op_q;
  logic [PS-1:0]             vld_q;
  logic [PS-1:0][TAG_W-1:0]  tag_q;
  logic [CW-1:0]             credit_q, credit_d;
  logic [15:0]               ovf_q, ovf_d;
  assign req_ready_o = rst_ni & ~req_full;
  assign {hx, hy, hop, htag} = req_head;
  // One credit per op between issue and response handshake keeps the response FIFO from overflowing.
  assign issue   = ~req_empty && (credit_q < CW'(RSP_DEPTH));
  assign rsp_valid_o = ~rsp_empty;
  assign rsp_pop = rsp_valid_o & rsp_ready_i;
  assign cap     = vld_q[PS-1];
  assign ovf_cap = cap & alu_overflow_i;
  assign {rsp_result_o, rsp_overflow_o, rsp_tag_o} = rsp_valid_o ? rsp_head : '0;
  assign alu_x_o     = alu_x_q;
  assign alu_y_o     = alu_y_q;
  assign alu_op_o    = alu_op_q;
  assign ovf_count_o = ovf_q;
  assign busy_o      = ~req_empty | (|vld_q) | ~rsp_empty;
  fp_sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_valid_i & req_ready_o),
    .pop_i   (issue),
    .din_i   ({req_x_i, req_y_i, req_op_i, req_tag_i}),
    .dout_o  (req_head),
    .full_o  (req_full),
    .empty_o (req_empty)
  );
  fp_sync_fifo #(.WIDTH(SW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cap),
    .pop_i   (rsp_pop),
    .din_i   ({alu_result_i, alu_overflow_i, tag_q[PS-1]}),
    .dout_o  (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );
  always_comb begin
    credit_d = credit_q + CW'(issue) - CW'(rsp_pop);
    ovf_d    = cnt_clr_i ? {15'd0, ovf_cap} : ovf_q + {15'd0, ovf_cap & ~&ovf_q};
  end
  // op_q holds the issued op for one cycle so alu_op trails alu_x/alu_y by one edge.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      alu_x_q  <= '0;
      alu_y_q  <= '0;
      op_q     <= 1'b0;
      alu_op_q <= 1'b0;
      vld_q    <= '0;
      tag_q    <= '0;
      credit_q <= '0;
      ovf_q    <= '0;
    end else begin
      alu_x_q  <= issue ? hx : '0;
      alu_y_q  <= issue ? hy : '0;
      op_q     <= issue & hop;
      alu_op_q <= op_q;
      vld_q    <= {vld_q[PS-2:0], issue};
      tag_q    <= {tag_q[PS-2:0], issue ? htag : TAG_W'(0)};
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  // Credits bound the response FIFO occupancy, so a capture never meets a full FIFO without a pop.
  always_ff @(posedge clk_i)
    if (rst_ni && cap) assert (!rsp_full || rsp_pop);
endmodule

// File: tb/tb_fp_alu_dispatcher.sv
// tb_fp_alu_dispatcher: directed, table-driven self-checking bench for fp_alu_dispatcher
module tb_fp_alu_dispatcher;
  import fp_alu_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [31:0] req_x = '0, req_y = '0;
  logic [3:0]  req_tag = '0;
  logic [31:0] alu_x, alu_y, alu_res = '0;
  logic        alu_op, alu_ovf = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_overflow;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        cnt_clr = 1'b0, busy;
  logic [15:0] ovf_count;
  fp_alu_dispatcher dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_x_i(req_x), .req_y_i(req_y), .req_op_i(req_op), .req_tag_i(req_tag),
    .alu_x_o(alu_x), .alu_y_o(alu_y), .alu_op_o(alu_op),
    .alu_result_i(alu_res), .alu_overflow_i(alu_ovf),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_overflow_o(rsp_overflow), .rsp_tag_o(rsp_tag),
    .cnt_clr_i(cnt_clr), .ovf_count_o(ovf_count), .busy_o(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // ALU reference: known IEEE-754 cases, otherwise a simple operand mix that still depends on op.
  function automatic logic [32:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic op);
    case ({op, x, y})
      {OP_ADD, 32'h3F800000, 32'h40000000}: return {1'b0, 32'h40400000};
      {OP_MUL, 32'h40000000, 32'h40400000}: return {1'b0, 32'h40C00000};
      {OP_ADD, 32'h40400000, 32'h40400000}: return {1'b0, 32'h40C00000};
      {OP_MUL, 32'h40000000, 32'h40000000}: return {1'b0, 32'h40800000};
      {OP_MUL, 32'h7F000000, 32'h7F000000}: return {1'b1, 32'h7F800000};
      {OP_ADD, 32'h3F800000, 32'h3F800000}: return {1'b0, 32'h40000000};
      default: return {1'b0, x ^ y ^ {31'b0, op}};
    endcase
  endfunction
  // ALU model: samples x/y at edge E, op at E+1, result valid after E+2.
  logic [31:0] xs = '0, ys = '0;
  logic [32:0] r1 = '0;
  always @(posedge clk) begin
    xs <= alu_x;
    ys <= alu_y;
    r1 <= alu_f(xs, ys, alu_op);
    {alu_ovf, alu_res} <= r1;
  end
  // Response and ALU-port monitors, sampled mid-low-phase.
  logic [36:0] rq[$];
  int          rc[$];
  logic [31:0] axq[$];
  logic        aoq[$];
  logic        mon = 1'b0;
  always @(negedge clk) begin
    #2;
    if (rsp_valid && rsp_ready) begin
      rq.push_back({rsp_tag, rsp_overflow, rsp_result});
      rc.push_back(cyc);
    end
    if (mon) begin
      axq.push_back(alu_x);
      aoq.push_back(alu_op);
    end
  end
  // Called right after a negedge; returns at the negedge following the accepting edge, req_valid still high.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic op, input logic [3:0] tag);
    int g = 0;
    req_valid = 1'b1; req_x = x; req_y = y; req_op = op; req_tag = tag;
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
  endtask
  typedef struct {
    logic [31:0] x, y;
    logic        op;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        ovf;
  } vec_t;
  vec_t        tv[6];
  int          lat, acc, c0;
  logic        accepted;
  logic [31:0] x2[4];
  logic        o2[4];
  initial begin
    tv[0] = '{32'h3F800000, 32'h40000000, OP_ADD, 4'd3,  32'h40400000, 1'b0};
    tv[1] = '{32'h40000000, 32'h40400000, OP_MUL, 4'd5,  32'h40C00000, 1'b0};
    tv[2] = '{32'h40400000, 32'h40400000, OP_ADD, 4'hF,  32'h40C00000, 1'b0};
    tv[3] = '{32'h40000000, 32'h40000000, OP_MUL, 4'd0,  32'h40800000, 1'b0};
    tv[4] = '{32'h7F000000, 32'h7F000000, OP_MUL, 4'd9,  32'h7F800000, 1'b1};
    tv[5] = '{32'h3F800000, 32'h3F800000, OP_ADD, 4'hA,  32'h40000000, 1'b0};
    x2 = '{32'h11, 32'h22, 32'h33, 32'h44};
    o2 = '{OP_ADD, OP_MUL, OP_ADD, OP_MUL};
    // Reset state
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_ovf_count", ovf_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_req_ready", req_ready, 1);
    @(negedge clk);
    // Single requests from an empty system: latency, result, tag, overflow
    for (int i = 0; i < 6; i++) begin
      send(tv[i].x, tv[i].y, tv[i].op, tv[i].tag);
      req_valid = 1'b0;
      wait_rsp(lat);
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_result", i), rsp_result, tv[i].res);
      chk($sformatf("vec%0d_tag", i), rsp_tag, tv[i].tag);
      chk($sformatf("vec%0d_ovf", i), rsp_overflow, tv[i].ovf);
      @(negedge clk);
    end
    chk("idle_busy", busy, 0);
    chk("idle_rsp_result", rsp_result, 0);
    chk("ovf_after_table", ovf_count, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_alone", ovf_count, 0);
    // Back-to-back: op skew and consecutive in-order responses
    rq.delete(); rc.delete(); axq.delete(); aoq.delete();
    mon = 1'b1;
    for (int k = 0; k < 4; k++) send(x2[k], 32'h0, o2[k], 4'(k));
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    mon = 1'b0;
    c0 = -1;
    for (int i = 0; i < axq.size(); i++) if (c0 < 0 && axq[i] == 32'h11) c0 = i;
    chk("b2b_issue_seen", c0 >= 0 && c0 + 5 <= aoq.size(), 1);
    if (c0 >= 0 && c0 + 5 <= aoq.size()) begin
      chk("b2b_op_before", aoq[c0], OP_ADD);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b2b_alu_x%0d", k), axq[c0+k], x2[k]);
        chk($sformatf("b2b_alu_op%0d", k), aoq[c0+k+1], o2[k]);
      end
    end
    chk("b2b_rsp_count", rq.size(), 4);
    if (rq.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b2b_tag%0d", k), rq[k][36:33], k);
        chk($sformatf("b2b_res%0d", k), rq[k][31:0], alu_f(x2[k], 32'h0, o2[k]) & 33'h0FFFFFFFF);
        chk($sformatf("b2b_cycle%0d", k), rc[k] - rc[0], k);
      end
    // Backpressure: 4 issued, 4 queued, rest held off, then all 10 drained in order
    rq.delete(); rc.delete();
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 90; c++) begin
      if (c == 30) begin
        chk("bp_accepts", acc, 8);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_head_tag", rsp_tag, 0);
        chk("bp_busy", busy, 1);
        rsp_ready = 1'b1;
      end
      req_valid = acc < 10;
      req_x = 32'h100 + 32'(acc); req_y = '0; req_op = OP_ADD; req_tag = acc[3:0];
      accepted = req_valid && req_ready;
      @(negedge clk);
      if (accepted) acc++;
    end
    req_valid = 1'b0;
    chk("bp_total_accepts", acc, 10);
    chk("bp_rsp_count", rq.size(), 10);
    if (rq.size() == 10)
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("bp_tag%0d", k), rq[k][36:33], k);
        chk($sformatf("bp_res%0d", k), rq[k][31:0], 32'h100 + 32'(k));
      end
    chk("bp_idle", busy, 0);
    // Overflow counting, clear colliding with a capture, saturation
    send(32'h7F000000, 32'h7F000000, OP_MUL, 4'd1);
    send(32'h7F000000, 32'h7F000000, OP_MUL, 4'd2);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("ovf_two", ovf_count, 2);
    send(32'h7F000000, 32'h7F000000, OP_MUL, 4'd3);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("ovf_clr_with_cap", ovf_count, 1);
    chk("ovf_clr_rsp_tag", rsp_tag, 3);
    chk("ovf_clr_rsp_ovf", rsp_overflow, 1);
    repeat (3) @(negedge clk);
    force dut.ovf_q = 16'hFFFD;
    #1 release dut.ovf_q;
    @(negedge clk);
    chk("ovf_preload", ovf_count, 16'hFFFD);
    for (int k = 0; k < 4; k++) send(32'h7F000000, 32'h7F000000, OP_MUL, 4'(k));
    req_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("ovf_saturate", ovf_count, 16'hFFFF);
    // Reset with ops in flight
    for (int k = 0; k < 3; k++) send(tv[0].x, tv[0].y, tv[0].op, 4'(4 + k));
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu_x", alu_x, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_ovf_count", ovf_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rq.delete(); rc.delete();
    repeat (15) @(negedge clk);
    chk("post_rst_no_rsp", rq.size(), 0);
    chk("post_rst_busy", busy, 0);
    send(tv[1].x, tv[1].y, tv[1].op, 4'd7);
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_result", rsp_result, tv[1].res);
    chk("post_rst_tag", rsp_tag, 7);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
